btle_adv_scan_ctrl: RTL and testbench
=====================================

# btle_adv_scan_ctrl

Scan scheduler that sequences the BLE receive core across the advertising channels 37/38/39. It drives the core's channel number, access address and CRC init, and holds the core in reset while retuning. It bounds each channel visit with a dwell timer and each packet with a receive timeout, and reports per-packet completion and CRC status upward.

## Interface
- CHANNEL_NUMBER_BIT_WIDTH, 6, channel number width.
- LEN_UNIQUE_BIT_SEQUENCE, 32, access-address width.
- CRC_STATE_BIT_WIDTH, 24, CRC init width.
- DWELL_WIDTH, 24, width of dwell counter and `dwell_cycles`.
- SETTLE_CYCLES, 4, cycles `core_rst` is held per retune (≥1).
- PKT_TIMEOUT, 65535, maximum cycles from hit to `decode_end`.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin scanning; honoured only in IDLE.
- stop  in  1  one-cycle abort; honoured in any non-IDLE state.
- ch_mask  in  3  enable for channels {39,38,37} (bit0 = 37); sampled on accepted `start`.
- dwell_cycles  in  DWELL_WIDTH  listen time per channel; sampled on accepted `start`; 0 is treated as 1.
- hit_flag  in  1  access-address hit from the core.
- decode_end  in  1  packet-finished pulse from the core.
- crc_ok  in  1  CRC result, valid with `decode_end`.
- core_rst  out  1  reset to the receive core.
- channel_number  out  CHANNEL_NUMBER_BIT_WIDTH  channel to the core.
- unique_bit_sequence  out  LEN_UNIQUE_BIT_SEQUENCE  constant 32'h8E89BED6.
- crc_state_init_bit  out  CRC_STATE_BIT_WIDTH  constant 24'h555555.
- busy  out  1  high in every state except IDLE.
- pkt_done  out  1  one-cycle pulse per completed packet.
- pkt_crc_ok  out  1  registered `crc_ok`, valid with `pkt_done`.
- pkt_channel  out  CHANNEL_NUMBER_BIT_WIDTH  channel of the reported packet.
- rx_timeout  out  1  one-cycle pulse when a packet exceeds PKT_TIMEOUT.

## Operation
- States: IDLE, RETUNE, LISTEN, RECEIVE.
- IDLE:
  - `core_rst`=1.
  - On `start` with `ch_mask`≠0: latch the mask and dwell value, load `channel_number` with the lowest enabled channel, go to RETUNE.
  - `start` with `ch_mask`=0 is ignored.
- RETUNE:
  - `core_rst`=1; settle counter counts SETTLE_CYCLES.
  - Then go to LISTEN with `core_rst`=0 and the dwell counter loaded.
- LISTEN:
  - Dwell counter decrements each cycle.
  - `hit_flag` → RECEIVE, timeout counter cleared.
  - Dwell expiry → load the next enabled channel (round robin 37→38→39→37, masked channels skipped) → RETUNE.
  - If `hit_flag` and dwell expiry occur in the same cycle, `hit_flag` wins.
- RECEIVE:
  - `decode_end` → pulse `pkt_done`, set `pkt_crc_ok`=`crc_ok` and `pkt_channel`=`channel_number`, advance channel, go to RETUNE.
  - Timeout counter reaching PKT_TIMEOUT → pulse `rx_timeout`, advance channel, go to RETUNE.
  - If `decode_end` and the timeout coincide, `decode_end` wins and `rx_timeout` stays 0.
- With a single enabled channel, "advance" reselects the same channel and RETUNE still runs.
- `stop`:
  - From any non-IDLE state → IDLE next cycle, `core_rst`=1.
  - A pending `decode_end` in the same cycle is dropped (no `pkt_done`).
  - `stop` has priority over every other event.
- The scan repeats indefinitely until `stop` or `rst`.
- Reset values:
  - state IDLE, `core_rst`=1, `busy`=0.
  - `channel_number`=37, `pkt_channel`=37.
  - `pkt_done`=0, `pkt_crc_ok`=0, `rx_timeout`=0.
  - all counters 0.
  - `unique_bit_sequence`/`crc_state_init_bit` at their constants.
- `rst` mid-scan returns to IDLE in one cycle without emitting pulses.

## Timing
- All outputs are registered.
- `start` at cycle t:
  - `busy`=1 and `channel_number` valid at t+1.
  - `core_rst` stays 1 through t+SETTLE_CYCLES.
  - `core_rst`=0 at t+SETTLE_CYCLES+1.
- LISTEN lasts exactly `dwell_cycles` cycles when there is no hit.
- `hit_flag` at cycle h → state RECEIVE at h+1.
- `decode_end` at cycle d → `pkt_done`/`pkt_crc_ok`/`pkt_channel` at d+1; `core_rst` rises at d+1; the new channel is valid at d+1.
- `rx_timeout` asserts PKT_TIMEOUT+1 cycles after the hit.
- `hit_flag`/`decode_end` are ignored outside LISTEN/RECEIVE respectively.

## Structure
- Shared package `btle_pkg`:
  - state encoding.
  - ADV_ACCESS_ADDRESS (32'h8E89BED6).
  - ADV_CRC_INIT (24'h555555).
  - channel constants 37/38/39.
- Sub-module `btle_adv_ch_next`: combinational; takes the current channel and the 3-bit mask and returns the next enabled advertising channel.
- Top instantiates `btle_adv_ch_next` alongside the receive core; the FSM and counters live in the controller.

## Test plan
- Mask 3'b111, dwell 100, no hits → channel sequence 37,38,39,37. Each LISTEN is 100 cycles; each `core_rst` pulse is 4 cycles.
- Mask 3'b101, hit at cycle 20 of LISTEN on 37, `decode_end` with `crc_ok`=1 after 500 cycles → one `pkt_done`, `pkt_crc_ok`=1, `pkt_channel`=37; the next channel is 39.
- Hit with no `decode_end` → `rx_timeout` pulses PKT_TIMEOUT+1 cycles after the hit; `pkt_done` never asserts; the scan continues.
- `hit_flag` coincident with dwell expiry → RECEIVE entered with no channel change. Also `decode_end` coincident with the timeout → `pkt_done` only.
- `stop` asserted in RECEIVE in the same cycle as `decode_end` → IDLE, `core_rst`=1, no `pkt_done`. `start` with mask 0 → remains IDLE with `busy`=0.
- `rst` asserted mid-LISTEN → all outputs at reset values next cycle; a subsequent `start` begins on the lowest enabled channel.

Source files
------------

// File: rtl/btle_pkg.sv
// Shared definitions for the BLE advertising scan scheduler: FSM encoding,
// advertising-channel access address / CRC seed, and channel numbers.
package btle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RETUNE  = 2'd1,
        ST_LISTEN  = 2'd2,
        ST_RECEIVE = 2'd3
    } scan_state_t;

    localparam logic [31:0] ADV_ACCESS_ADDRESS = 32'h8E89BED6;
    localparam logic [23:0] ADV_CRC_INIT       = 24'h555555;

    localparam int unsigned ADV_CH_37 = 37;
    localparam int unsigned ADV_CH_38 = 38;
    localparam int unsigned ADV_CH_39 = 39;

    // Lowest enabled advertising channel of a mask (bit0 = 37); 37 if none.
    function automatic int unsigned first_adv_channel(input logic [2:0] mask);
        if (mask[0])      return ADV_CH_37;
        else if (mask[1]) return ADV_CH_38;
        else if (mask[2]) return ADV_CH_39;
        else              return ADV_CH_37;
    endfunction

endpackage

// File: rtl/btle_adv_ch_next.sv
// Round-robin advertising channel selector: returns the next enabled channel
// after cur_ch in the order 37 -> 38 -> 39 -> 37, skipping masked channels.
// A single enabled channel selects itself; an empty mask holds cur_ch.
module btle_adv_ch_next
    import btle_pkg::*;
#(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6
) (
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] cur_ch,
    input  logic [2:0]                          ch_mask,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] next_ch
);

    localparam logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] CH37 = CHANNEL_NUMBER_BIT_WIDTH'(ADV_CH_37);
    localparam logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] CH38 = CHANNEL_NUMBER_BIT_WIDTH'(ADV_CH_38);
    localparam logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] CH39 = CHANNEL_NUMBER_BIT_WIDTH'(ADV_CH_39);

    // Search the two following channels, then the current one, in ring order.
    always_comb begin
        next_ch = cur_ch;
        case (cur_ch)
            CH38: begin
                if (ch_mask[2])      next_ch = CH39;
                else if (ch_mask[0]) next_ch = CH37;
                else if (ch_mask[1]) next_ch = CH38;
            end
            CH39: begin
                if (ch_mask[0])      next_ch = CH37;
                else if (ch_mask[1]) next_ch = CH38;
                else if (ch_mask[2]) next_ch = CH39;
            end
            default: begin
                if (ch_mask[1])      next_ch = CH38;
                else if (ch_mask[2]) next_ch = CH39;
                else if (ch_mask[0]) next_ch = CH37;
            end
        endcase
    end

endmodule

// File: rtl/btle_adv_scan_ctrl.sv
// Advertising scan scheduler. Steps the receive core across channels 37/38/39,
// holding it in reset while retuning, bounding each visit with a dwell timer
// and each packet with a receive timeout, and reporting packet completion.
module btle_adv_scan_ctrl
    import btle_pkg::*;
#(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int DWELL_WIDTH              = 24,
    parameter int SETTLE_CYCLES            = 4,
    parameter int PKT_TIMEOUT              = 65535
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                stop,
    input  logic [2:0]                          ch_mask,
    input  logic [DWELL_WIDTH-1:0]              dwell_cycles,
    input  logic                                hit_flag,
    input  logic                                decode_end,
    input  logic                                crc_ok,
    output logic                                core_rst,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    output logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  unique_bit_sequence,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
    output logic                                busy,
    output logic                                pkt_done,
    output logic                                pkt_crc_ok,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] pkt_channel,
    output logic                                rx_timeout
);

    localparam int CHW  = CHANNEL_NUMBER_BIT_WIDTH;
    localparam int SW   = $clog2(SETTLE_CYCLES + 1);
    localparam int TW   = $clog2(PKT_TIMEOUT + 1);
    localparam logic [CHW-1:0]         CH37        = CHW'(ADV_CH_37);
    localparam logic [SW-1:0]          SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    // Counter reads PKT_TIMEOUT-1 in the last permitted RECEIVE cycle, so the
    // registered rx_timeout lands PKT_TIMEOUT+1 cycles after the hit.
    localparam logic [TW-1:0]          TO_LAST     = TW'(PKT_TIMEOUT - 1);
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE   = DWELL_WIDTH'(1);

    scan_state_t            state_q, state_d;
    logic [SW-1:0]          settle_cnt;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [TW-1:0]          to_cnt;
    logic [2:0]             mask_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [CHW-1:0]         ch_next;
    logic                   accept_start;
    logic                   pkt_fire;
    logic                   to_fire;
    logic                   advance;

    assign unique_bit_sequence = LEN_UNIQUE_BIT_SEQUENCE'(ADV_ACCESS_ADDRESS);
    assign crc_state_init_bit  = CRC_STATE_BIT_WIDTH'(ADV_CRC_INIT);

    btle_adv_ch_next #(
        .CHANNEL_NUMBER_BIT_WIDTH(CHW)
    ) u_ch_next (
        .cur_ch  (channel_number),
        .ch_mask (mask_q),
        .next_ch (ch_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and event decode; stop overrides every other event.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        pkt_fire     = 1'b0;
        to_fire      = 1'b0;
        advance      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (ch_mask != 3'b000)) begin
                    accept_start = 1'b1;
                    state_d      = ST_RETUNE;
                end
            end
            ST_RETUNE: begin
                if (settle_cnt == SETTLE_LAST) state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
                if (hit_flag) begin
                    state_d = ST_RECEIVE;
                end else if (dwell_cnt == DWELL_ONE) begin
                    advance = 1'b1;
                    state_d = ST_RETUNE;
                end
            end
            ST_RECEIVE: begin
                if (decode_end) begin
                    pkt_fire = 1'b1;
                    advance  = 1'b1;
                    state_d  = ST_RETUNE;
                end else if (to_cnt == TO_LAST) begin
                    to_fire = 1'b1;
                    advance = 1'b1;
                    state_d = ST_RETUNE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (stop && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            pkt_fire = 1'b0;
            to_fire  = 1'b0;
            advance  = 1'b0;
        end
    end

    // Registered outputs, channel selection, scan configuration and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst       <= 1'b1;
            busy           <= 1'b0;
            channel_number <= CH37;
            pkt_channel    <= CH37;
            pkt_done       <= 1'b0;
            pkt_crc_ok     <= 1'b0;
            rx_timeout     <= 1'b0;
            settle_cnt     <= '0;
            dwell_cnt      <= '0;
            to_cnt         <= '0;
            mask_q         <= '0;
            dwell_q        <= '0;
        end else begin
            core_rst   <= (state_d == ST_IDLE) || (state_d == ST_RETUNE);
            busy       <= (state_d != ST_IDLE);
            pkt_done   <= pkt_fire;
            rx_timeout <= to_fire;
            if (pkt_fire) begin
                pkt_crc_ok  <= crc_ok;
                pkt_channel <= channel_number;
            end
            if (accept_start) begin
                mask_q         <= ch_mask;
                dwell_q        <= (dwell_cycles == '0) ? DWELL_ONE : dwell_cycles;
                channel_number <= CHW'(first_adv_channel(ch_mask));
            end else if (advance) begin
                channel_number <= ch_next;
            end
            settle_cnt <= ((state_q == ST_RETUNE) && (state_d == ST_RETUNE)) ? settle_cnt + 1'b1 : '0;
            if (state_d == ST_LISTEN)
                dwell_cnt <= (state_q == ST_LISTEN) ? dwell_cnt - 1'b1 : dwell_q;
            else
                dwell_cnt <= '0;
            if (state_d == ST_RECEIVE)
                to_cnt <= (state_q == ST_RECEIVE) ? to_cnt + 1'b1 : '0;
            else
                to_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_btle_adv_scan_ctrl.sv
// Bench for btle_adv_scan_ctrl: a phase/remaining-cycles model predicts every
// registered output each cycle, and directed sequences pin key instants with
// literal values.
module tb_btle_adv_scan_ctrl;

    localparam int CHW     = 6;
    localparam int DW      = 24;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [2:0]    ch_mask = 3'b000;
    logic [DW-1:0] dwell_cycles = '0;
    logic          hit_flag = 1'b0;
    logic          decode_end = 1'b0;
    logic          crc_ok = 1'b0;
    logic          core_rst;
    logic [CHW-1:0] channel_number;
    logic [31:0]   unique_bit_sequence;
    logic [23:0]   crc_state_init_bit;
    logic          busy;
    logic          pkt_done;
    logic          pkt_crc_ok;
    logic [CHW-1:0] pkt_channel;
    logic          rx_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    btle_adv_scan_ctrl #(
        .CHANNEL_NUMBER_BIT_WIDTH(CHW),
        .LEN_UNIQUE_BIT_SEQUENCE(32),
        .CRC_STATE_BIT_WIDTH(24),
        .DWELL_WIDTH(DW),
        .SETTLE_CYCLES(SETTLE),
        .PKT_TIMEOUT(TIMEOUT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .stop                (stop),
        .ch_mask             (ch_mask),
        .dwell_cycles        (dwell_cycles),
        .hit_flag            (hit_flag),
        .decode_end          (decode_end),
        .crc_ok              (crc_ok),
        .core_rst            (core_rst),
        .channel_number      (channel_number),
        .unique_bit_sequence (unique_bit_sequence),
        .crc_state_init_bit  (crc_state_init_bit),
        .busy                (busy),
        .pkt_done            (pkt_done),
        .pkt_crc_ok          (pkt_crc_ok),
        .pkt_channel         (pkt_channel),
        .rx_timeout          (rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 retuning, 2 listening, 3 receiving
    int m_phase = 0;
    int m_left  = 0;
    int m_age   = 0;
    int m_mask  = 0;
    int m_dwell = 0;
    int e_ch    = 37;
    int e_pch   = 37;
    bit e_crc   = 1'b0;
    bit e_done  = 1'b0;
    bit e_to    = 1'b0;

    function automatic int first_ch(input int mask);
        for (int k = 0; k < 3; k++) if (((mask >> k) & 1) != 0) return 37 + k;
        return 37;
    endfunction

    function automatic int following_ch(input int ch, input int mask);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = 37 + ((ch - 37 + k) % 3);
            if (((mask >> (c - 37)) & 1) != 0) return c;
        end
        return ch;
    endfunction

    always @(posedge clk) begin
        cyc++;
        e_done = 1'b0;
        e_to   = 1'b0;
        if (rst) begin
            m_phase = 0; m_left = 0; m_age = 0;
            e_ch = 37; e_pch = 37; e_crc = 1'b0;
        end else if (stop && m_phase != 0) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (start && ch_mask != 3'b000) begin
                    m_mask  = int'(ch_mask);
                    m_dwell = (dwell_cycles == 0) ? 1 : int'(dwell_cycles);
                    e_ch    = first_ch(m_mask);
                    m_phase = 1; m_left = SETTLE;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 2; m_left = m_dwell; end
                end
                2: if (hit_flag) begin
                    m_phase = 3; m_age = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        e_ch = following_ch(e_ch, m_mask); m_phase = 1; m_left = SETTLE;
                    end
                end
                default: begin
                    m_age++;
                    if (decode_end) begin
                        e_done = 1'b1; e_crc = crc_ok; e_pch = e_ch;
                        e_ch = following_ch(e_ch, m_mask); m_phase = 1; m_left = SETTLE;
                    end else if (m_age == TIMEOUT) begin
                        e_to = 1'b1;
                        e_ch = following_ch(e_ch, m_mask); m_phase = 1; m_left = SETTLE;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("m_core_rst", core_rst, (m_phase <= 1));
            chk("m_busy", busy, (m_phase != 0));
            chk("m_channel", channel_number, e_ch);
            chk("m_pkt_done", pkt_done, e_done);
            chk("m_pkt_crc_ok", pkt_crc_ok, e_crc);
            chk("m_pkt_channel", pkt_channel, e_pch);
            chk("m_rx_timeout", rx_timeout, e_to);
            chk("m_access_addr", unique_bit_sequence, 32'h8E89BED6);
            chk("m_crc_init", crc_state_init_bit, 24'h555555);
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        step(3);
        rst = 1'b0;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_channel", channel_number, 37);
        chk("rst_pkt_channel", pkt_channel, 37);

        // all three channels, dwell 100, no hits
        start = 1'b1; ch_mask = 3'b111; dwell_cycles = 100;
        step(1); start = 1'b0;
        chk("s1_busy", busy, 1);
        chk("s1_channel", channel_number, 37);
        step(3);  chk("s1_settle_last", core_rst, 1);
        step(1);  chk("s1_listen_core_rst", core_rst, 0);
        step(99); chk("s1_listen_end_ch", channel_number, 37);
        chk("s1_listen_end_rst", core_rst, 0);
        step(1);  chk("s1_ch38", channel_number, 38);
        chk("s1_retune_rst", core_rst, 1);
        step(104); chk("s1_ch39", channel_number, 39);
        step(104); chk("s1_ch37_again", channel_number, 37);

        // abort, then mask 101 with a good packet on 37
        stop = 1'b1; step(1); stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_core_rst", core_rst, 1);
        start = 1'b1; ch_mask = 3'b101; dwell_cycles = 100;
        step(1); start = 1'b0;
        step(4);  chk("s2_listen", core_rst, 0);
        step(19); hit_flag = 1'b1; step(1); hit_flag = 1'b0;
        step(499); decode_end = 1'b1; crc_ok = 1'b1;
        step(1); decode_end = 1'b0; crc_ok = 1'b0;
        chk("s2_pkt_done", pkt_done, 1);
        chk("s2_pkt_crc_ok", pkt_crc_ok, 1);
        chk("s2_pkt_channel", pkt_channel, 37);
        chk("s2_next_ch", channel_number, 39);
        chk("s2_core_rst", core_rst, 1);
        step(1);  chk("s2_pkt_done_pulse", pkt_done, 0);

        // hit with no decode_end on 39 -> timeout, scan moves to 37
        step(3);  chk("s3_listen", core_rst, 0);
        hit_flag = 1'b1; step(1); hit_flag = 1'b0;
        step(TIMEOUT - 1); chk("s3_not_yet", rx_timeout, 0);
        step(1);  chk("s3_timeout", rx_timeout, 1);
        chk("s3_no_pkt", pkt_done, 0);
        chk("s3_next_ch", channel_number, 37);

        // hit on the dwell-expiry cycle, then decode_end on the timeout cycle
        step(4);  step(99);
        hit_flag = 1'b1; step(1); hit_flag = 1'b0;
        chk("s4_hit_ch", channel_number, 37);
        chk("s4_receiving", core_rst, 0);
        step(TIMEOUT - 1); decode_end = 1'b1; crc_ok = 1'b0;
        step(1); decode_end = 1'b0;
        chk("s4_pkt_done", pkt_done, 1);
        chk("s4_no_timeout", rx_timeout, 0);
        chk("s4_crc_bad", pkt_crc_ok, 0);
        chk("s4_next_ch", channel_number, 39);

        // stop coincident with decode_end drops the packet
        step(4); hit_flag = 1'b1; step(1); hit_flag = 1'b0;
        step(10); stop = 1'b1; decode_end = 1'b1; crc_ok = 1'b1;
        step(1); stop = 1'b0; decode_end = 1'b0; crc_ok = 1'b0;
        chk("s5_busy", busy, 0);
        chk("s5_core_rst", core_rst, 1);
        chk("s5_no_pkt", pkt_done, 0);
        start = 1'b1; ch_mask = 3'b000; step(1); start = 1'b0;
        step(3); chk("s5_mask0_idle", busy, 0);

        // reset mid-LISTEN, then restart with dwell 0 on mask 110
        start = 1'b1; ch_mask = 3'b110; dwell_cycles = 50; step(1); start = 1'b0;
        chk("s6_first_ch", channel_number, 38);
        step(14); rst = 1'b1; step(1); rst = 1'b0;
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_core_rst", core_rst, 1);
        chk("s6_rst_ch", channel_number, 37);
        start = 1'b1; ch_mask = 3'b110; dwell_cycles = 0; step(1); start = 1'b0;
        chk("s6_restart_ch", channel_number, 38);
        step(4); chk("s6_listen1", core_rst, 0);
        step(1); chk("s6_dwell0_ch", channel_number, 39);
        chk("s6_dwell0_rst", core_rst, 1);

        // single enabled channel still retunes onto itself
        stop = 1'b1; step(1); stop = 1'b0;
        start = 1'b1; ch_mask = 3'b010; dwell_cycles = 3; step(1); start = 1'b0;
        step(4); chk("s7_listen", core_rst, 0);
        step(3); chk("s7_same_ch", channel_number, 38);
        chk("s7_retune", core_rst, 1);
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
